// File: rtl/control_unit.sv
// control_unit -- hardwired Moore control sequencer for a small RISC datapath.
//
// Sequences fetch (T0..T2), decode and per-opcode execute states, and drives
// the datapath's bus-drive, register-load, ALU-select and memory strobes.
// Outputs depend only on the registered state and the opcode class captured
// at the end of T2. The one exception is PCin in the branch T6 state, which
// is qualified by CON_FF.
//
// Ports
//   Clock, Clear            : clock; synchronous active-high reset
//   IR[31:0]                : instruction register (opcode = IR[31:27])
//   CON_FF, MemRdy, Stop    : branch condition, memory-ready, halt request
//   PCout..MDRout           : bus drive enables
//   MARin..Yin              : register load enables
//   IncPC, Read, Write      : PC increment and memory strobes
//   Gra..CONIn              : register-select / constant controls
//   ADD, SUB, AND, OR       : ALU operation selects
//   Run, IllegalOp          : running flag; one-cycle undefined-opcode pulse
module control_unit #(
  parameter int MEM_WAIT = 1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        MemRdy,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zhiout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        CONIn,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        Run,
  output logic        IllegalOp
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // S_T0_ILL behaves exactly like T0 but also raises IllegalOp, so the pulse
  // remains a pure state decode.
  typedef enum logic [3:0] {
    S_RST, S_HALT, S_T0, S_T0_ILL, S_T1, S_T2,
    S_T3, S_T4, S_T5, S_T6, S_T7
  } state_t;

  typedef enum logic [2:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_ADDI, C_BR
  } cls_t;

  state_t     state, state_nxt;
  cls_t       cls_q, cls_d;
  logic [1:0] aop_q, aop_d;       // 0 add, 1 sub, 2 and, 3 or
  logic       exec_op;
  logic       mem_ok;
  state_t     done_nxt;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign mem_ok    = (MEM_WAIT == 0) ? 1'b1 : MemRdy;
  // Instruction boundary: Stop is honoured only here.
  assign done_nxt  = Stop ? S_HALT : S_T0;

  always_ff @(posedge Clock) begin
    if (Clear) state <= S_RST;
    else       state <= state_nxt;
  end

  // Opcode class is latched as T2 retires; it steers the shared T3..T7 states.
  always_ff @(posedge Clock) begin
    if (state == S_T2) begin
      cls_q <= cls_d;
      aop_q <= aop_d;
    end
  end

  always_comb begin
    cls_d   = C_LD;
    aop_d   = 2'd0;
    exec_op = 1'b1;
    case (opcode)
      OP_LD:   cls_d = C_LD;
      OP_LDI:  cls_d = C_LDI;
      OP_ST:   cls_d = C_ST;
      OP_ADD:  begin cls_d = C_ALU; aop_d = 2'd0; end
      OP_SUB:  begin cls_d = C_ALU; aop_d = 2'd1; end
      OP_AND:  begin cls_d = C_ALU; aop_d = 2'd2; end
      OP_OR:   begin cls_d = C_ALU; aop_d = 2'd3; end
      OP_ADDI: cls_d = C_ADDI;
      OP_BR:   cls_d = C_BR;
      default: exec_op = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:             state_nxt = S_T0;
      S_HALT:            state_nxt = S_HALT;
      S_T0, S_T0_ILL:    state_nxt = S_T1;
      S_T1:              state_nxt = mem_ok ? S_T2 : S_T1;
      S_T2: begin
        if (exec_op)                state_nxt = S_T3;
        else if (opcode == OP_NOP)  state_nxt = done_nxt;
        else if (opcode == OP_HALT) state_nxt = S_HALT;
        else                        state_nxt = S_T0_ILL;
      end
      S_T3:              state_nxt = S_T4;
      S_T4:              state_nxt = S_T5;
      S_T5: begin
        if (cls_q == C_LD || cls_q == C_ST || cls_q == C_BR) state_nxt = S_T6;
        else                                                 state_nxt = done_nxt;
      end
      S_T6: begin
        if (cls_q == C_LD)      state_nxt = mem_ok ? S_T7 : S_T6;
        else if (cls_q == C_ST) state_nxt = S_T7;
        else                    state_nxt = done_nxt;
      end
      S_T7: begin
        if (cls_q == C_ST) state_nxt = mem_ok ? done_nxt : S_T7;
        else               state_nxt = done_nxt;
      end
      default:           state_nxt = S_RST;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zhiout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; CONIn = 1'b0;
    ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR = 1'b0;
    IllegalOp = 1'b0;
    Run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0, S_T0_ILL: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        IllegalOp = (state == S_T0_ILL);
      end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (cls_q == C_BR) begin
          Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1;
        end else if (cls_q == C_LD || cls_q == C_LDI || cls_q == C_ST) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
      end
      S_T4: begin
        if (cls_q == C_BR) begin
          PCout = 1'b1; Yin = 1'b1;
        end else if (cls_q == C_ALU) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
          ADD = (aop_q == 2'd0);
          SUB = (aop_q == 2'd1);
          AND = (aop_q == 2'd2);
          OR  = (aop_q == 2'd3);
        end else begin
          Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
        end
      end
      S_T5: begin
        if (cls_q == C_BR) begin
          Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
        end else if (cls_q == C_LD || cls_q == C_ST) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin
        if (cls_q == C_LD) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (cls_q == C_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (cls_q == C_BR) begin
          Zlowout = 1'b1; PCin = CON_FF;
        end
      end
      S_T7: begin
        if (cls_q == C_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (cls_q == C_ST) begin
          MDRout = 1'b1; Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, meaning: 1 = memory states stall until MemRdy; 0 = memory states last exactly one cycle.
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port Clear, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port IR, input, 32 bits: instruction register contents; opcode is IR[31:27].
REQ-005 SHALL have port CON_FF, input, 1 bit: branch condition flag from the datapath.
REQ-006 SHALL have port MemRdy, input, 1 bit: memory access complete.
REQ-007 SHALL have port Stop, input, 1 bit: halt request.
REQ-008 SHALL have outputs PCout, Zhiout, Zlowout, MDRout, each 1 bit: bus drive enables.
REQ-009 SHALL have outputs MARin, Zin, PCin, MDRin, IRin, Yin, each 1 bit: register load enables.
REQ-010 SHALL have outputs IncPC, Read, Write, each 1 bit: PC increment and memory strobes.
REQ-011 SHALL have outputs Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, each 1 bit: register-select and constant controls.
REQ-012 SHALL have outputs ADD, SUB, AND, OR, each 1 bit: ALU operation selects.
REQ-013 SHALL have outputs Run and IllegalOp, each 1 bit: processor running; one-cycle pulse on an undefined opcode.

Function
REQ-014 SHALL implement a Moore FSM: every output is a decode of the registered state only, with no input-to-output combinational path except CON_FF in state BR_T6.
REQ-015 SHALL deassert every control output not listed for the current state.
REQ-016 SHALL run fetch as T0 (PCout, MARin, IncPC, Zin), then T1 (Zlowout, PCin, Read, MDRin), then T2 (MDRout, IRin).
REQ-017 SHALL decode IR[31:27] at the end of T2 using: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, br=10010, nop=11010, halt=11011.
REQ-018 SHALL execute ld as T3 (Grb, BAout, Yin), T4 (Cout, ADD, Zin), T5 (Zlowout, MARin), T6 (Read, MDRin), T7 (MDRout, Gra, Rin).
REQ-019 SHALL execute ldi as T3 and T4 identical to ld, then T5 (Zlowout, Gra, Rin).
REQ-020 SHALL execute st as T3 to T5 identical to ld, then T6 (Gra, Rout, MDRin), T7 (MDRout, Write).
REQ-021 SHALL execute add/sub/and/or as T3 (Grb, Rout, Yin), T4 (Grc, Rout, op select, Zin), T5 (Zlowout, Gra, Rin).
REQ-022 SHALL execute addi as T3 (Grb, Rout, Yin), T4 (Cout, ADD, Zin), T5 (Zlowout, Gra, Rin).
REQ-023 SHALL execute br as T3 (Gra, Rout, CONIn), T4 (PCout, Yin), T5 (Cout, ADD, Zin), T6 (Zlowout, PCin qualified by CON_FF).
REQ-024 SHALL return from nop to T0 directly after T2.
REQ-025 SHALL treat an undefined opcode as nop and pulse IllegalOp for one cycle in the cycle after T2.
REQ-026 SHALL return to T0 after the last execute state of every instruction.
REQ-027 SHALL, when MEM_WAIT=1, hold fetch T1, ld T6 and st T7 (outputs held) until MemRdy=1 is sampled, then advance.
REQ-028 SHALL, when MEM_WAIT=0, ignore MemRdy.
REQ-029 SHALL enter HALT after T2 on opcode halt, or at any return to T0 while Stop=1.
REQ-030 SHALL, in HALT, drive Run=0 with all control outputs 0, and leave HALT only on Clear.
REQ-031 SHALL let Stop take effect only at an instruction boundary; an instruction in progress completes.

Reset
REQ-032 SHALL, when Clear=1 at a rising edge, force the FSM to state RST regardless of the current state, including mid-instruction and during memory waits.
REQ-033 SHALL drive Run=0, IllegalOp=0 and all control outputs 0 in RST.
REQ-034 SHALL go from RST to T0 on the first edge with Clear=0, and drive Run=1 from T0 onward.

Verification
REQ-035 SHALL cover: Clear pulse, then IR=0x1080005A (st), MemRdy=1 -> T0..T7 occur in 8 cycles after RST, with MDRout and Write both high in T7 only.
REQ-036 SHALL cover: IR=0x00800055 (ld), MemRdy low for 3 cycles in T6 -> Read and MDRin stay high for 4 cycles; Gra and Rin high for exactly 1 cycle.
REQ-037 SHALL cover: br with CON_FF=0 and then with CON_FF=1 -> PCin high in BR_T6 only when CON_FF=1.
REQ-038 SHALL cover: IR[31:27]=11111 -> IllegalOp pulses once and the next state is T0; IR[31:27]=11011 -> Run=0 and the FSM stays in HALT for 20 cycles.
REQ-039 SHALL cover: Clear asserted in st T5 -> all outputs 0 next cycle, then T0 with Run=1.
REQ-040 SHALL cover: Stop asserted during add T4 -> T5 completes, then HALT.
